coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB_CYCLES, default 4, cycles a synchronized sensor must hold a level to be accepted (legal range 2..15).
REQ-002 Parameter MAX_CYCLES, default 64, maximum qualified coin-pulse length before jam (legal range DEB_CYCLES+1..255).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sens_5  input  1  raw, asynchronous 5-unit coin-chute sensor, high while coin passes.
REQ-006 sens_10  input  1  raw, asynchronous 10-unit coin-chute sensor, high while coin passes.
REQ-007 accept  input  1  downstream vending FSM can take a coin this cycle (low while it is vending).
REQ-008 coin  output  2  coin code to vending FSM: 00 none, 01 five, 10 ten; 11 never driven.
REQ-009 reject  output  1  one-cycle pulse: coin event discarded (both sensors, or jam cleared).
REQ-010 jam  output  1  level: sensor held high beyond MAX_CYCLES.
REQ-011 busy  output  1  level: FSM not in IDLE.

Function
REQ-012 Each sensor SHALL pass through a two-flop synchronizer; the FSM SHALL use only synchronized values.
REQ-013 FSM states SHALL be IDLE, QUAL, HOLD, PEND, REJ, SETTLE; cnt is an 8-bit saturating counter.
REQ-014 IDLE: exactly one sensor high -> QUAL, latch coin type, cnt=1; both high -> REJ; none -> stay.
REQ-015 QUAL: latched sensor still high alone -> cnt+1; cnt reaching DEB_CYCLES -> HOLD; latched sensor low before that -> IDLE, no output (glitch).
REQ-016 QUAL/HOLD: other sensor going high -> REJ.
REQ-017 HOLD: cnt increments; cnt reaching MAX_CYCLES sets jam and stays HOLD; sensor low with jam=0 -> PEND; sensor low with jam=1 -> REJ.
REQ-018 PEND: accept=1 -> coin driven with latched code for exactly one cycle starting next cycle, FSM -> SETTLE; accept=0 -> stay, coin=00, sensors ignored.
REQ-019 REJ: reject pulses high one cycle, jam clears, FSM -> SETTLE.
REQ-020 SETTLE: both sensors low for DEB_CYCLES consecutive cycles -> IDLE; any high sample restarts the count.
REQ-021 Latency: raw sensor fall to coin valid SHALL be 4 clk edges when accept=1 throughout (2 sync + HOLD->PEND + PEND->out).
REQ-022 coin SHALL be 00 in every cycle except the single emission cycle; at most one emission per accepted coin.
REQ-023 coin, reject, jam, busy SHALL be registered outputs.
REQ-024 busy SHALL be low only in IDLE.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, cnt=0, synchronizers=0, coin=00, reject=0, jam=0, busy=0.
REQ-026 Reset mid-operation (any state, including PEND) SHALL discard the coin in flight with no coin or reject output.
REQ-027 Release of rst is synchronous to clk; the first post-reset sensor sample is 2 edges later.

Structure
REQ-028 Coin codes (COIN_NONE, COIN_5, COIN_10) and FSM state encodings SHALL live in the shared vending package/include also used by the vending FSM.
REQ-029 One sub-module, coin_sync (two-flop synchronizer, 1-bit), SHALL be instantiated per sensor.
REQ-030 Target size 150-250 lines RTL; no other sub-modules.

Verification (DEB_CYCLES=4, MAX_CYCLES=64)
REQ-031 sens_5 high 10 cycles, accept=1 -> coin=01 for one cycle, 4 edges after fall; busy low DEB_CYCLES+ cycles later.
REQ-032 sens_10 high 2 cycles (glitch) -> coin stays 00, no reject, FSM returns IDLE.
REQ-033 sens_10 high 10 cycles, accept=0 for 20 cycles then 1 -> coin=10 once, one cycle after accept rises.
REQ-034 sens_5 and sens_10 high together 8 cycles -> reject single pulse, coin stays 00.
REQ-035 sens_5 held 100 cycles -> jam high from cnt=64, reject pulse after fall, jam cleared, no coin.
REQ-036 rst low while in PEND with accept=0 -> all outputs 0 immediately; no coin after reset release.

Source files
------------

// File: rtl/coin_acceptor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor_pkg
// Description : Shared vending definitions: coin codes, coin-acceptor FSM
//               state encoding and a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_acceptor_pkg;

   // Coin codes exchanged with the vending FSM; 2'b11 is never produced.
   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_5    = 2'b01,
      COIN_10   = 2'b10
   } coin_t;

   // Coin-acceptor FSM states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_QUAL   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_PEND   = 3'd3,
      ST_REJ    = 3'd4,
      ST_SETTLE = 3'd5
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_sync.sv
`default_nettype none
// ============================================================================
// Module      : coin_sync
// Description : Two-flop synchronizer for one raw asynchronous sensor bit.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the raw level; reset clears both stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Debounces two coin-chute sensors, classifies the coin,
//               detects jams and double-sensor events, and hands exactly one
//               coin code per accepted coin to the vending FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int MAX_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sens_5,
   input  logic       sens_10,
   input  logic       accept,
   output logic [1:0] coin,
   output logic       reject,
   output logic       jam,
   output logic       busy
);

   localparam logic [7:0] c_DEB_CNT = 8'(DEB_CYCLES);
   localparam logic [7:0] c_MAX_CNT = 8'(MAX_CYCLES);

   // Synchronized sensor levels; the FSM never looks at the raw inputs.
   logic w_s5;
   logic w_s10;

   coin_sync u_sync_5 (
      .clk (clk),
      .rst (rst),
      .i_d (sens_5),
      .o_q (w_s5)
   );

   coin_sync u_sync_10 (
      .clk (clk),
      .rst (rst),
      .i_d (sens_10),
      .o_q (w_s10)
   );

   state_t     r_state;
   logic [7:0] r_cnt;
   coin_t      r_type;
   coin_t      r_coin;
   logic       r_reject;
   logic       r_jam;
   logic       r_busy;

   state_t     w_state_nx;
   logic [7:0] w_cnt_nx;
   coin_t      w_type_nx;
   coin_t      w_coin_nx;
   logic       w_reject_nx;
   logic       w_jam_nx;
   logic [7:0] w_inc;
   logic       w_mine;
   logic       w_other;

   // "mine" is the sensor of the latched coin type, "other" the opposite one.
   assign w_inc   = sat_inc(r_cnt);
   assign w_mine  = (r_type == COIN_10) ? w_s10 : w_s5;
   assign w_other = (r_type == COIN_10) ? w_s5  : w_s10;

   // State, counter and output registers; outputs are computed one cycle ahead.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_type   <= COIN_NONE;
         r_coin   <= COIN_NONE;
         r_reject <= 1'b0;
         r_jam    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_type   <= w_type_nx;
         r_coin   <= w_coin_nx;
         r_reject <= w_reject_nx;
         r_jam    <= w_jam_nx;
         r_busy   <= (w_state_nx != ST_IDLE);
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_type_nx   = r_type;
      w_coin_nx   = COIN_NONE;
      w_reject_nx = 1'b0;
      w_jam_nx    = r_jam;

      case (r_state)
         ST_IDLE: begin
            if (w_s5 && w_s10) begin
               w_state_nx = ST_REJ;
               w_cnt_nx   = 8'd0;
            end else if (w_s5 || w_s10) begin
               w_state_nx = ST_QUAL;
               w_type_nx  = w_s10 ? COIN_10 : COIN_5;
               w_cnt_nx   = 8'd1;
            end
         end

         ST_QUAL: begin
            if (w_other) begin
               w_state_nx = ST_REJ;
            end else if (!w_mine) begin
               // Too short to be a coin: drop it silently.
               w_state_nx = ST_IDLE;
               w_cnt_nx   = 8'd0;
            end else begin
               w_cnt_nx = w_inc;
               if (w_inc >= c_DEB_CNT) begin
                  w_state_nx = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (w_other) begin
               w_state_nx = ST_REJ;
            end else if (!w_mine) begin
               w_state_nx = r_jam ? ST_REJ : ST_PEND;
            end else begin
               w_cnt_nx = w_inc;
               if (w_inc >= c_MAX_CNT) begin
                  w_jam_nx = 1'b1;
               end
            end
         end

         ST_PEND: begin
            // Sensors are ignored while the vending FSM is busy.
            if (accept) begin
               w_coin_nx  = r_type;
               w_state_nx = ST_SETTLE;
               w_cnt_nx   = 8'd0;
            end
         end

         ST_REJ: begin
            w_reject_nx = 1'b1;
            w_jam_nx    = 1'b0;
            w_state_nx  = ST_SETTLE;
            w_cnt_nx    = 8'd0;
         end

         ST_SETTLE: begin
            // Require a quiet chute for DEB_CYCLES consecutive samples.
            if (w_s5 || w_s10) begin
               w_cnt_nx = 8'd0;
            end else if (w_inc >= c_DEB_CNT) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = 8'd0;
            end else begin
               w_cnt_nx = w_inc;
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 8'd0;
         end
      endcase
   end

   assign coin   = r_coin;
   assign reject = r_reject;
   assign jam    = r_jam;
   assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Self-checking bench for coin_acceptor (DEB_CYCLES=4,
//               MAX_CYCLES=64) with an expected-event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

   logic       clk;
   logic       rst;
   logic       sens_5;
   logic       sens_10;
   logic       accept;
   logic [1:0] coin;
   logic       reject;
   logic       jam;
   logic       busy;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  coin;
      logic        rej;
   } ev_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   rd_idx = 0;
   ev_t  obs[$];
   ev_t  exp_q[$];

   coin_acceptor #(
      .DEB_CYCLES (4),
      .MAX_CYCLES (64)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sens_5  (sens_5),
      .sens_10 (sens_10),
      .accept  (accept),
      .coin    (coin),
      .reject  (reject),
      .jam     (jam),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter used to timestamp events.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every cycle that carries a coin or a reject pulse.
   always @(negedge clk) begin
      if (coin != 2'b00 || reject)
         obs.push_back({32'(cyc), coin, reject});
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0; sens_5 = 1'b0; sens_10 = 1'b0; accept = 1'b1;
      tick(3);
      total++; if (coin !== 2'b00) begin bad++; $display("FAIL reset_coin: got %b, want 00", coin); end
      total++; if (reject !== 1'b0) begin bad++; $display("FAIL reset_reject: got %b, want 0", reject); end
      total++; if (jam !== 1'b0) begin bad++; $display("FAIL reset_jam: got %b, want 0", jam); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
      rst = 1'b1;
      tick(3);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b, want 0", busy); end
   endtask

   task automatic test_coin5;
      int c0, cf;
      ev_t o, e;
      accept = 1'b1; sens_5 = 1'b1; c0 = cyc;
      exp_q.push_back({32'(c0 + 14), 2'b01, 1'b0});
      tick(10);
      sens_5 = 1'b0; cf = cyc;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL coin5_busy_hold: got %b, want 1", busy); end
      tick(7);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL coin5_busy_settle: got %b, want 1 at cf+7", busy); end
      tick(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin5_busy_idle: got %b, want 0 at cf+8", busy); end
      tick(2);
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL coin5_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL coin5_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d coin=%b rej=%b", o.cyc, o.coin, o.rej, e.cyc, e.coin, e.rej); end end
      end
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); total++; bad++; $display("FAIL coin5_missing: got nothing, want cyc=%0d coin=%b rej=%b", e.cyc, e.coin, e.rej); end
   endtask

   task automatic test_glitch;
      int c0;
      ev_t o, e;
      sens_10 = 1'b1; c0 = cyc;
      tick(2);
      sens_10 = 1'b0;
      tick(2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_qual: got %b, want 1", busy); end
      tick(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_idle: got %b, want 0", busy); end
      tick(6);
      total++; if (obs.size() != rd_idx) begin bad++; $display("FAIL glitch_events: got %0d events, want 0", obs.size() - rd_idx); end
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL glitch_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL glitch_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d", o.cyc, o.coin, o.rej, e.cyc); end end
      end
   endtask

   task automatic test_accept_wait;
      int c0;
      ev_t o, e;
      accept = 1'b0; sens_10 = 1'b1; c0 = cyc;
      exp_q.push_back({32'(c0 + 21), 2'b10, 1'b0});
      tick(10);
      sens_10 = 1'b0;
      tick(10);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend_busy: got %b, want 1", busy); end
      accept = 1'b1;
      tick(10);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL pend_busy_idle: got %b, want 0", busy); end
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL pend_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL pend_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d coin=%b rej=%b", o.cyc, o.coin, o.rej, e.cyc, e.coin, e.rej); end end
      end
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); total++; bad++; $display("FAIL pend_missing: got nothing, want cyc=%0d coin=%b", e.cyc, e.coin); end
   endtask

   task automatic test_both;
      int c0;
      ev_t o, e;
      sens_5 = 1'b1; sens_10 = 1'b1; c0 = cyc;
      exp_q.push_back({32'(c0 + 4), 2'b00, 1'b1});
      tick(8);
      sens_5 = 1'b0; sens_10 = 1'b0;
      tick(5);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL both_busy_settle: got %b, want 1", busy); end
      tick(7);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_busy_idle: got %b, want 0", busy); end
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL both_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL both_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d coin=%b rej=%b", o.cyc, o.coin, o.rej, e.cyc, e.coin, e.rej); end end
      end
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); total++; bad++; $display("FAIL both_missing: got nothing, want reject at cyc=%0d", e.cyc); end
   endtask

   task automatic test_jam;
      int c0, cf;
      ev_t o, e;
      sens_5 = 1'b1; c0 = cyc;
      tick(65);
      total++; if (jam !== 1'b0) begin bad++; $display("FAIL jam_early: got %b, want 0 at cnt=63", jam); end
      tick(1);
      total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_set: got %b, want 1 at cnt=64", jam); end
      tick(34);
      sens_5 = 1'b0; cf = cyc;
      exp_q.push_back({32'(cf + 4), 2'b00, 1'b1});
      tick(3);
      total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_hold: got %b, want 1 before reject", jam); end
      tick(1);
      total++; if (jam !== 1'b0) begin bad++; $display("FAIL jam_clear: got %b, want 0 with reject", jam); end
      tick(6);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL jam_busy_idle: got %b, want 0", busy); end
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL jam_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL jam_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d coin=%b rej=%b", o.cyc, o.coin, o.rej, e.cyc, e.coin, e.rej); end end
      end
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); total++; bad++; $display("FAIL jam_missing: got nothing, want reject at cyc=%0d", e.cyc); end
   endtask

   task automatic test_reset_pend;
      ev_t o;
      accept = 1'b0; sens_5 = 1'b1;
      tick(10);
      sens_5 = 1'b0;
      tick(5);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rpend_busy_pre: got %b, want 1", busy); end
      rst = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rpend_busy: got %b, want 0", busy); end
      total++; if (coin !== 2'b00) begin bad++; $display("FAIL rpend_coin: got %b, want 00", coin); end
      total++; if (reject !== 1'b0) begin bad++; $display("FAIL rpend_reject: got %b, want 0", reject); end
      total++; if (jam !== 1'b0) begin bad++; $display("FAIL rpend_jam: got %b, want 0", jam); end
      tick(1);
      rst = 1'b1; accept = 1'b1;
      tick(15);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rpend_busy_after: got %b, want 0", busy); end
      total++; if (obs.size() != rd_idx) begin bad++; $display("FAIL rpend_events: got %0d events, want 0", obs.size() - rd_idx); end
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++;
         $display("FAIL rpend_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej);
      end
   endtask

   task automatic test_back_to_back;
      int c0, c1;
      ev_t o, e;
      accept = 1'b1; sens_5 = 1'b1; c0 = cyc;
      exp_q.push_back({32'(c0 + 14), 2'b01, 1'b0});
      tick(10);
      sens_5 = 1'b0;
      tick(10);
      sens_10 = 1'b1; c1 = cyc;
      exp_q.push_back({32'(c1 + 16), 2'b10, 1'b0});
      tick(12);
      sens_10 = 1'b0;
      tick(12);
      while (rd_idx < obs.size()) begin
         o = obs[rd_idx]; rd_idx++; total++;
         if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra: got cyc=%0d coin=%b rej=%b, want none", o.cyc, o.coin, o.rej); end
         else begin e = exp_q.pop_front(); if (o !== e) begin bad++; $display("FAIL b2b_event: got cyc=%0d coin=%b rej=%b, want cyc=%0d coin=%b rej=%b", o.cyc, o.coin, o.rej, e.cyc, e.coin, e.rej); end end
      end
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); total++; bad++; $display("FAIL b2b_missing: got nothing, want cyc=%0d coin=%b", e.cyc, e.coin); end
   endtask

   initial begin
      rst = 1'b0; sens_5 = 1'b0; sens_10 = 1'b0; accept = 1'b1;
      @(negedge clk);
      test_reset();
      test_coin5();
      test_glitch();
      test_accept_wait();
      test_both();
      test_jam();
      test_reset_pend();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
